// File: rtl/mem_req_issue.sv
// mem_req_issue: serialises a two-slot bundle of memory ops onto the dcache
// request port, slot 0 first. It builds byte strobes, replicates store data,
// flags misaligned addresses, and holds the pipeline paused until every
// issued request has returned data_ok.
//
// Handshakes: a bundle is taken on in_valid && in_ready. A dcache request
// transfers on req_valid && req_addr_ok, and the request fields hold steady
// until then. Each accepted request returns exactly one req_data_ok, either
// in the same cycle as addr_ok or later. data_ok is ignored in IDLE, DONE
// and ISSUE without addr_ok.
module mem_req_issue #(
    parameter int ISSUE_WIDTH = 2,
    parameter int ADDR_W      = 32
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 flush,
    input  logic                                 in_valid,
    output logic                                 in_ready,
    input  logic [ISSUE_WIDTH-1:0]               mem_en,
    input  logic [ISSUE_WIDTH-1:0]               is_store,
    input  logic [ISSUE_WIDTH-1:0][1:0]          size,
    input  logic [ISSUE_WIDTH-1:0][ADDR_W-1:0]   addr,
    input  logic [ISSUE_WIDTH-1:0][ADDR_W-1:0]   st_data,
    input  logic [ISSUE_WIDTH-1:0]               excp_in,
    output logic                                 req_valid,
    output logic                                 req_we,
    output logic [ADDR_W-1:0]                    req_addr,
    output logic [3:0]                           req_wstrb,
    output logic [ADDR_W-1:0]                    req_wdata,
    input  logic                                 req_addr_ok,
    input  logic                                 req_data_ok,
    input  logic [ADDR_W-1:0]                    req_rdata,
    output logic                                 done_valid,
    output logic [ISSUE_WIDTH-1:0][ADDR_W-1:0]   ld_rdata,
    output logic [ISSUE_WIDTH-1:0]               ale,
    output logic                                 pause_o,
    output logic [2:0]                           dbg_state
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        WAIT  = 3'd2,
        DONE  = 3'd3,
        DRAIN = 3'd4
    } state_t;

    state_t                              state;
    logic                                slot_q;
    logic [ISSUE_WIDTH-1:0]              iss_q;
    logic [ISSUE_WIDTH-1:0]              st_q;
    logic [ISSUE_WIDTH-1:0][1:0]         sz_q;
    logic [ISSUE_WIDTH-1:0][ADDR_W-1:0]  addr_q;
    logic [ISSUE_WIDTH-1:0][ADDR_W-1:0]  data_q;

    logic [ISSUE_WIDTH-1:0]              ale_n;
    logic [ISSUE_WIDTH-1:0]              iss_n;
    logic                                more_slots;

    // Byte enables for one op; loads never write.
    function automatic logic [3:0] strb_f(input logic st, input logic [1:0] sz,
                                          input logic [1:0] a);
        if (!st) return 4'b0000;
        case (sz)
            2'b00:   return 4'b0001 << a;
            2'b01:   return 4'b0011 << {a[1], 1'b0};
            default: return 4'b1111;
        endcase
    endfunction

    // Store data replicated across the word so any lane the strobe picks is valid.
    function automatic logic [ADDR_W-1:0] wdata_f(input logic [1:0] sz,
                                                  input logic [ADDR_W-1:0] d);
        case (sz)
            2'b00:   return {4{d[7:0]}};
            2'b01:   return {2{d[15:0]}};
            default: return d;
        endcase
    endfunction

    // Misalignment: half needs addr[0]=0, word (and size 11) needs addr[1:0]=00.
    function automatic logic ale_f(input logic en, input logic [1:0] sz,
                                   input logic [1:0] a);
        return en && (((sz == 2'b01) && a[0]) || (sz[1] && (a != 2'b00)));
    endfunction

    // Per-slot fault and issue decision at accept; a fault in slot 0 blocks slot 1.
    always_comb begin
        ale_n[0] = ale_f(mem_en[0], size[0], addr[0][1:0]);
        ale_n[1] = ale_f(mem_en[1], size[1], addr[1][1:0]);
        iss_n[0] = mem_en[0] && !excp_in[0] && !ale_n[0];
        iss_n[1] = mem_en[1] && !excp_in[1] && !ale_n[1] && !excp_in[0] && !ale_n[0];
    end

    // Slot 1 still has to go out once the current slot-0 request completes.
    assign more_slots = (slot_q == 1'b0) && iss_q[1];

    assign in_ready  = (state == IDLE) && !flush;
    assign dbg_state = state;

    // Main control FSM with registered request, completion and stall outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            slot_q     <= 1'b0;
            iss_q      <= '0;
            st_q       <= '0;
            sz_q       <= '0;
            addr_q     <= '0;
            data_q     <= '0;
            req_valid  <= 1'b0;
            req_we     <= 1'b0;
            req_addr   <= '0;
            req_wstrb  <= 4'b0000;
            req_wdata  <= '0;
            done_valid <= 1'b0;
            ld_rdata   <= '0;
            ale        <= '0;
            pause_o    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done_valid <= 1'b0;
                    if (in_valid && !flush) begin
                        iss_q    <= iss_n;
                        st_q     <= is_store;
                        sz_q     <= size;
                        addr_q   <= addr;
                        data_q   <= st_data;
                        ale      <= ale_n;
                        ld_rdata <= '0;
                        if (iss_n[0] || iss_n[1]) begin
                            // Slot 1 may go first only when slot 0 is not a memory op.
                            slot_q    <= !iss_n[0];
                            req_valid <= 1'b1;
                            req_we    <= iss_n[0] ? is_store[0] : is_store[1];
                            req_addr  <= iss_n[0] ? {addr[0][ADDR_W-1:2], 2'b00}
                                                  : {addr[1][ADDR_W-1:2], 2'b00};
                            req_wstrb <= iss_n[0] ? strb_f(is_store[0], size[0], addr[0][1:0])
                                                  : strb_f(is_store[1], size[1], addr[1][1:0]);
                            req_wdata <= iss_n[0] ? wdata_f(size[0], st_data[0])
                                                  : wdata_f(size[1], st_data[1]);
                            pause_o   <= 1'b1;
                            state     <= ISSUE;
                        end else begin
                            done_valid <= 1'b1;
                            pause_o    <= 1'b0;
                            state      <= DONE;
                        end
                    end
                end

                ISSUE: begin
                    if (flush && !req_addr_ok) begin
                        // Nothing handed to the dcache yet, so the request can simply vanish.
                        req_valid <= 1'b0;
                        pause_o   <= 1'b0;
                        state     <= IDLE;
                    end else if (req_addr_ok) begin
                        req_valid <= 1'b0;
                        if (flush) begin
                            // Accepted request must still return; drain it unless it already did.
                            pause_o <= !req_data_ok;
                            state   <= req_data_ok ? IDLE : DRAIN;
                        end else if (!req_data_ok) begin
                            state <= WAIT;
                        end else begin
                            if (!st_q[slot_q]) ld_rdata[slot_q] <= req_rdata;
                            if (more_slots) begin
                                slot_q    <= 1'b1;
                                req_valid <= 1'b1;
                                req_we    <= st_q[1];
                                req_addr  <= {addr_q[1][ADDR_W-1:2], 2'b00};
                                req_wstrb <= strb_f(st_q[1], sz_q[1], addr_q[1][1:0]);
                                req_wdata <= wdata_f(sz_q[1], data_q[1]);
                                state     <= ISSUE;
                            end else begin
                                done_valid <= 1'b1;
                                pause_o    <= 1'b0;
                                state      <= DONE;
                            end
                        end
                    end
                end

                WAIT: begin
                    if (req_data_ok) begin
                        if (flush) begin
                            pause_o <= 1'b0;
                            state   <= IDLE;
                        end else begin
                            if (!st_q[slot_q]) ld_rdata[slot_q] <= req_rdata;
                            if (more_slots) begin
                                slot_q    <= 1'b1;
                                req_valid <= 1'b1;
                                req_we    <= st_q[1];
                                req_addr  <= {addr_q[1][ADDR_W-1:2], 2'b00};
                                req_wstrb <= strb_f(st_q[1], sz_q[1], addr_q[1][1:0]);
                                req_wdata <= wdata_f(sz_q[1], data_q[1]);
                                state     <= ISSUE;
                            end else begin
                                done_valid <= 1'b1;
                                pause_o    <= 1'b0;
                                state      <= DONE;
                            end
                        end
                    end else if (flush) begin
                        state <= DRAIN;
                    end
                end

                DONE: begin
                    done_valid <= 1'b0;
                    state      <= IDLE;
                end

                DRAIN: begin
                    // Response of a flushed request is dropped on the floor.
                    if (req_data_ok) begin
                        pause_o <= 1'b0;
                        state   <= IDLE;
                    end
                end

                default: begin
                    req_valid  <= 1'b0;
                    done_valid <= 1'b0;
                    pause_o    <= 1'b0;
                    state      <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/mem_req_issue.md
Name: mem_req_issue

Overview:
- Sits in the memory-request half of ex, directly upstream of the mem stage.
- Takes a dual-issue bundle of memory ops and issues them to the dcache one at a time, slot 0 first.
- Generates byte strobes, replicated store data and address-misalignment (ALE) flags.
- Holds the pipeline paused until every issued request has returned data_ok, then presents the raw read words to mem for extension.

Parameters:
- ISSUE_WIDTH, 2, number of slots per bundle; the logic is specified for exactly 2.
- ADDR_W, 32, address and data width.

Ports:
- clk  in  1  clock
- rst  in  1  reset: synchronous, active-high
- flush  in  1  pipeline flush from ctrl
- in_valid  in  1  ex presents a bundle
- in_ready  out  1  bundle accepted when in_valid && in_ready
- mem_en  in  2  per-slot: slot is a memory op
- is_store  in  2  per-slot: 1 = store/sc.w, 0 = load/ll.w
- size  in  2x2  per-slot: 00 byte, 01 half, 10 word, 11 treated as word
- addr  in  2x32  per-slot address
- st_data  in  2x32  per-slot store source register value
- excp_in  in  2  per-slot: earlier exception already raised
- req_valid  out  1  dcache request valid
- req_we  out  1  1 = write
- req_addr  out  32  word-aligned request address
- req_wstrb  out  4  byte enables; 0000 for loads
- req_wdata  out  32  replicated store data
- req_addr_ok  in  1  dcache accepted the request
- req_data_ok  in  1  dcache response
- req_rdata  in  32  dcache read word
- done_valid  out  1  one-cycle pulse: bundle finished
- ld_rdata  out  2x32  raw read word per slot, held until next acceptance
- ale  out  2  per-slot misalignment flag, held until next acceptance
- pause_o  out  1  stall request to ctrl

Behaviour:
- State machine states: IDLE, ISSUE, WAIT, DONE, DRAIN.
- Reset values: state=IDLE; in_ready=1; req_valid=0; req_we=0; req_addr=0; req_wstrb=0; req_wdata=0; done_valid=0; ld_rdata=0; ale=00; pause_o=0.
- in_ready = (state==IDLE). Accepting a bundle latches all slot fields.
- ALE per slot, computed at accept: half with addr[0]=1; word (or size 11) with addr[1:0]!=00.
- A slot issues iff mem_en && !excp_in && !ale, and no lower slot has excp_in or ale. Exceptions are precise: a faulting slot 0 suppresses slot 1.
- IDLE: on accept, go to ISSUE if any slot issues, otherwise DONE.
- ISSUE: req_valid=1 for the current slot. On addr_ok, go to WAIT. data_ok may arrive in the same cycle as addr_ok; it is then consumed immediately, as in WAIT.
- WAIT: on data_ok, latch req_rdata into ld_rdata[slot] (loads only). Go to ISSUE for the next issuing slot, else DONE.
- DONE: done_valid=1 for one cycle, then IDLE. The earliest next acceptance is the cycle after DONE.
- pause_o = state in {ISSUE, WAIT, DRAIN}.
- Latency: accept at cycle T; req_valid first asserted at T+1. A single load with zero-wait dcache (addr_ok and data_ok at T+1) gives DONE at T+2.
- req_addr = {addr[31:2], 2'b00}.
- req_wstrb:
  - byte: 0001 << addr[1:0]
  - half: 0011 << {addr[1], 1'b0}
  - word: 1111
  - load: 0000
- req_wdata:
  - byte: {4{st_data[7:0]}}
  - half: {2{st_data[15:0]}}
  - word: st_data
- Request fields stay stable while req_valid=1 and addr_ok=0.
- flush:
  - In IDLE or DONE: go to IDLE, with no done_valid pulse.
  - In ISSUE before addr_ok: drop req_valid the next cycle, go to IDLE.
  - In ISSUE with addr_ok in the same cycle, or in WAIT: go to DRAIN. An accepted request cannot be cancelled.
  - DRAIN: wait for data_ok, discard it, go to IDLE. No further slot issues.
  - A flush coincident with in_valid never accepts: in_ready is forced to 0 that cycle.
- data_ok in IDLE, ISSUE (without addr_ok) or DONE is ignored.
- rst mid-transaction returns to reset values the next cycle. The dcache is reset by the same rst.

Test Plan:
- Slot0 ld.w addr=0x1000, slot1 none; addr_ok and data_ok at T+1, rdata=0xDEADBEEF -> req_addr=0x1000, wstrb=0000, done_valid at T+2, ld_rdata[0]=0xDEADBEEF, pause_o high only at T+1.
- Slot0 st.b addr=0x2003 data=0x000000AB; slot1 st.h addr=0x2002 data=0x1234 -> two sequential requests: wstrb=1000 wdata=0xABABABAB, then wstrb=1100 wdata=0x12341234; done_valid after the second data_ok.
- Slot0 ld.h addr=0x3001, slot1 ld.w addr=0x4000 -> ale=01, no req_valid at all, done_valid at T+1.
- Slot0 excp_in=1, slot1 ld.w -> no request issued, done_valid at T+1, ale=00.
- Slot0 ld.w, addr_ok at T+1, flush at T+2, data_ok at T+4 -> DRAIN until T+4, no done_valid, in_ready=1 at T+5, slot1 never issued.
- ISSUE with addr_ok held low 3 cycles -> req_addr/wstrb/wdata stable throughout; rst asserted in cycle 2 -> req_valid=0 and in_ready=1 the next cycle.
